// File: rtl/exit_gate_dispatcher.sv
// exit_gate_dispatcher: pops one car ID at a time from the queue read port,
// opens the gate for that car, waits for the pass sensor (or times out) and
// then holds the gate closed for a guard interval before serving the next car.
module exit_gate_dispatcher #(
    parameter int ID_WIDTH     = 16,
    parameter int OPEN_CYCLES  = 1000,
    parameter int GUARD_CYCLES = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_b,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [ID_WIDTH-1:0]  fifo_dout,
    output logic                 ren_b,
    input  logic                 car_passed,
    output logic                 gate_open,
    output logic [ID_WIDTH-1:0]  car_id,
    output logic                 car_id_valid,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] served_count,
    output logic                 busy
);

    localparam int OT_W = (OPEN_CYCLES  > 1) ? $clog2(OPEN_CYCLES)  : 1;
    localparam int GT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [OT_W-1:0] OPEN_LAST  = OT_W'(OPEN_CYCLES - 1);
    localparam logic [GT_W-1:0] GUARD_LAST = GT_W'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        OPEN  = 3'd3,
        CLOSE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [OT_W-1:0]      open_tmr_q, open_tmr_d;
    logic [GT_W-1:0]      guard_tmr_q, guard_tmr_d;
    logic [ID_WIDTH-1:0]  car_id_q, car_id_d;
    logic [CNT_WIDTH-1:0] served_q, served_d;
    logic                 tmo_q, tmo_d;

    // State, timers, captured ID and counters; everything clears on reset.
    always_ff @(posedge clk_b) begin
        if (!rst) begin
            state_q     <= IDLE;
            open_tmr_q  <= '0;
            guard_tmr_q <= '0;
            car_id_q    <= '0;
            served_q    <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            open_tmr_q  <= open_tmr_d;
            guard_tmr_q <= guard_tmr_d;
            car_id_q    <= car_id_d;
            served_q    <= served_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next-state logic; the timeout flag is a one-cycle pulse that lands in the first CLOSE cycle.
    always_comb begin
        state_d     = state_q;
        open_tmr_d  = open_tmr_q;
        guard_tmr_d = guard_tmr_q;
        car_id_d    = car_id_q;
        served_d    = served_q;
        tmo_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                // Queue data is valid one cycle after the strobe, so sample it in LOAD.
                state_d = LOAD;
            end
            LOAD: begin
                car_id_d   = fifo_dout;
                open_tmr_d = '0;
                state_d    = OPEN;
            end
            OPEN: begin
                open_tmr_d = open_tmr_q + 1'b1;
                if (car_passed) begin
                    // A pass on the last OPEN cycle still counts as served.
                    if (served_q != {CNT_WIDTH{1'b1}}) begin
                        served_d = served_q + 1'b1;
                    end
                    guard_tmr_d = '0;
                    state_d     = CLOSE;
                end else if (open_tmr_q == OPEN_LAST) begin
                    tmo_d       = 1'b1;
                    guard_tmr_d = '0;
                    state_d     = CLOSE;
                end
            end
            CLOSE: begin
                if (guard_tmr_q == GUARD_LAST) begin
                    state_d = IDLE;
                end else begin
                    guard_tmr_d = guard_tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode from the registered state.
    always_comb begin
        ren_b        = (state_q == POP);
        gate_open    = (state_q == OPEN);
        car_id_valid = (state_q == OPEN);
        busy         = (state_q != IDLE);
        timeout_err  = tmo_q;
        car_id       = car_id_q;
        served_count = served_q;
    end

endmodule

// File: doc/exit_gate_dispatcher.md
# exit_gate_dispatcher

Read-side consumer for the car-ID queue. Pops one 16-bit car ID at a time from the queue's read port and opens the gate for that car. It then waits for the pass sensor, or times out, and closes the gate for a guard interval before serving the next car. It sits between the queue read side (clock domain b) and the gate actuator/sensor logic.

## Interface
- ID_WIDTH, 16, width of a queued car ID; equals the queue data width
- OPEN_CYCLES, 1000, maximum cycles the gate stays open waiting for car_passed (≥1)
- GUARD_CYCLES, 4, cycles the gate stays closed after each car before the next pop (≥1)
- CNT_WIDTH, 16, width of served_count
- clk_b  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-low reset
- enable  in  1  system enable; low blocks new pops only
- fifo_empty  in  1  queue empty flag
- fifo_dout  in  ID_WIDTH  queue read data; valid the cycle after ren_b
- ren_b  out  1  queue read strobe; exactly one cycle per car
- car_passed  in  1  pass sensor, sampled only in OPEN
- gate_open  out  1  gate actuator command
- car_id  out  ID_WIDTH  ID of the car being served
- car_id_valid  out  1  car_id meaningful (high in OPEN)
- timeout_err  out  1  one-cycle pulse when OPEN expires without car_passed
- served_count  out  CNT_WIDTH  cars that passed; saturates at all-ones
- busy  out  1  state ≠ IDLE

## Operation
- Reset (rst=0 at an edge): state IDLE. ren_b, gate_open, car_id_valid, timeout_err, busy = 0. car_id = 0, served_count = 0, timers = 0.
- States: IDLE, POP, LOAD, OPEN, CLOSE. All outputs are Moore-decoded from registered state/regs.
- IDLE: if enable=1 and fifo_empty=0, go to POP; else stay.
- POP: ren_b=1 for this cycle only. fifo_empty is not re-checked. Go to LOAD.
- LOAD: capture fifo_dout into car_id at the end of the cycle. Clear open_timer. Go to OPEN.
- OPEN: gate_open=1, car_id_valid=1, open_timer increments each cycle.
  - car_passed=1 → CLOSE; served_count+1 (held if all-ones).
  - Else, if open_timer==OPEN_CYCLES-1 → CLOSE; timeout_err=1 in the first CLOSE cycle; served_count unchanged.
  - car_passed on the final OPEN cycle counts as served: no timeout_err.
- CLOSE: gate_open=0, car_id_valid=0, car_id retains its value. Stay exactly GUARD_CYCLES cycles, then IDLE.
- car_passed outside OPEN is ignored.
- enable=0 only blocks IDLE→POP. A car already popped completes the full sequence.
- Synchronous reset mid-operation: next edge returns to the reset state. gate_open drops on that edge; a popped-but-unserved ID is lost; served_count clears.

## Timing
- Cycle 0: IDLE, enable=1, fifo_empty=0.
- Cycle 1: POP, ren_b=1.
- Cycle 2: LOAD, fifo_dout valid.
- Cycle 3: OPEN, gate_open=1, car_id valid.
- Pop-to-gate latency is 3 cycles from the sampling edge.
- car_passed sampled high in OPEN cycle k: CLOSE from cycle k+1; served_count updated at the edge ending cycle k.
- Timeout with no car_passed: OPEN lasts exactly OPEN_CYCLES cycles. timeout_err is high in the first CLOSE cycle.
- Per-car minimum period (pass on first OPEN cycle): 1 IDLE + 1 POP + 1 LOAD + 1 OPEN + GUARD_CYCLES = 4 + GUARD_CYCLES cycles.
- Maximum period (timeout): 3 + OPEN_CYCLES + GUARD_CYCLES cycles.
- Back-to-back cars: a second ren_b never occurs less than 4 + GUARD_CYCLES cycles after the first.

## Test plan
- Reset, then fifo_empty=0, enable=1, fifo_dout=16'h00A5 after POP, car_passed on the 2nd OPEN cycle → ren_b pulse in cycle 1; gate_open cycles 3–4; car_id=16'h00A5; served_count=1; no timeout_err.
- Same flow with OPEN_CYCLES=8 and car_passed never asserted → gate_open exactly 8 cycles; one timeout_err pulse; served_count=0; IDLE after 4 guard cycles.
- Three queued IDs 1, 2, 3, each passing on the first OPEN cycle, GUARD_CYCLES=4 → ren_b pulses exactly 8 cycles apart; car_id sequence 1, 2, 3; served_count=3.
- car_passed on the final OPEN cycle (cycle OPEN_CYCLES-1) → served_count increments; timeout_err stays 0. Also: car_passed pulsed during IDLE/CLOSE → ignored.
- enable=0 with fifo_empty=0 → no ren_b. Drop enable mid-OPEN → transaction completes, then stays IDLE.
- Assert rst=0 for one cycle during OPEN → gate_open=0, busy=0, served_count=0 at the next edge. Force served_count to all-ones plus one pass → stays all-ones.
